// File: rtl/fifo_framer_pkg.sv
// Shared types and constants for the FIFO read-side framer.
// Holds the framer state encoding, header magic and default sizes.
package fifo_framer_pkg;

    localparam int DEF_DSIZE     = 16;
    localparam int DEF_FRAME_LEN = 4;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

endpackage

// File: rtl/fifo_framer_csum.sv
// Running modulo-2^DSIZE sum of payload words for the frame checksum.
// Clear has priority over accumulate; carries out of the top bit are dropped.
module fifo_framer_csum #(
    parameter int DSIZE = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             acc_i,
    input  logic [DSIZE-1:0] data_i,
    output logic [DSIZE-1:0] sum_o
);

    logic [DSIZE-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (acc_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/fifo_rd_framer.sv
// Pops a first-word-fall-through FIFO and emits framed words:
// header {A5, seq}, FRAME_LEN payload words, then a checksum marked last.
module fifo_rd_framer
    import fifo_framer_pkg::*;
#(
    parameter int DSIZE     = DEF_DSIZE,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             r_en,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [7:0]       frame_cnt
);

    state_t           state_q, state_d;
    logic             armed_q;
    logic [7:0]       seq_q;
    logic [7:0]       cnt_q;
    logic [7:0]       frame_cnt_q;
    logic [DSIZE-1:0] data_q;
    logic             valid_q;
    logic             last_q;
    logic [DSIZE-1:0] sum;

    logic slot_free;
    logic last_word;
    logic ld_hdr;
    logic pop;
    logic ld_csum;

    assign slot_free = ~valid_q | out_ready;
    assign last_word = (cnt_q == 8'(FRAME_LEN - 1));

    // armed_q delays the first state change to the second edge after reset release
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (armed_q && !rempty) state_d = ST_HDR;
            ST_HDR:     if (slot_free) state_d = ST_PAYLOAD;
            ST_PAYLOAD: if (pop && last_word) state_d = ST_CSUM;
            ST_CSUM:    if (slot_free) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_hdr  = 1'b0;
        pop     = 1'b0;
        ld_csum = 1'b0;
        case (state_q)
            ST_HDR:     ld_hdr  = slot_free;
            ST_PAYLOAD: pop     = slot_free & ~rempty;
            ST_CSUM:    ld_csum = slot_free;
            default:    ;
        endcase
    end

    assign r_en = pop;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            seq_q       <= 8'd0;
            cnt_q       <= 8'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            if (ld_hdr) begin
                cnt_q <= 8'd0;
            end else if (pop) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (ld_csum) begin
                seq_q <= seq_q + 8'd1;
            end
            if (valid_q && out_ready && last_q) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    // Output register: a new word only enters when the slot is free
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (ld_hdr) begin
            data_q  <= DSIZE'({HDR_MAGIC, seq_q});
            valid_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (pop) begin
            data_q  <= rdata;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (ld_csum) begin
            data_q  <= sum;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
        end else if (slot_free) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    fifo_framer_csum #(
        .DSIZE (DSIZE)
    ) u_csum (
        .clk_i  (rclk),
        .rst_ni (rrst_n),
        .clr_i  (ld_hdr),
        .acc_i  (pop),
        .data_i (rdata),
        .sum_o  (sum)
    );

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Bench for fifo_rd_framer: FIFO model feeding the DUT, framed-stream
// reference model, and per-scenario checks of the captured output stream.
module tb_fifo_rd_framer;

    localparam int DW = 16;
    localparam int FL = 4;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic [DW-1:0] rdata;
    logic          rempty;
    logic          r_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [7:0]    frame_cnt;

    logic [DW-1:0] mem [2048];
    int wr_ptr = 0;
    int rd_ptr = 0;

    int checks = 0;
    int errors = 0;

    logic [DW:0] exp_q[$];
    logic [DW:0] cap_q[$];
    logic [7:0]    m_seq;
    logic [DW-1:0] m_sum;
    int            m_pos;
    int            m_frames;

    logic          lat_pend = 1'b0;
    logic [DW-1:0] lat_word;
    logic          hold_pend = 1'b0;
    logic [DW:0]   hold_word;

    fifo_rd_framer #(
        .DSIZE     (DW),
        .FRAME_LEN (FL)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rdata     (rdata),
        .rempty    (rempty),
        .r_en      (r_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    always #5 rclk = ~rclk;

    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr[10:0]];

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rd_ptr <= 0;
        else if (r_en && !rempty) rd_ptr <= rd_ptr + 1;
    end

    // Monitor: pop safety, one-cycle latency, hold-while-stalled, capture.
    always @(negedge rclk) begin
        if (rrst_n) begin
            checks++;
            if (r_en && rempty) begin
                errors++;
                $display("FAIL ren_empty r_en=%b rempty=%b need r_en=0", r_en, rempty);
            end
            if (lat_pend) begin
                checks++;
                if (!out_valid || out_data !== lat_word) begin
                    errors++;
                    $display("FAIL latency got=%h v=%b want=%h", out_data, out_valid, lat_word);
                end
            end
            if (hold_pend) begin
                checks++;
                if (!out_valid || {out_last, out_data} !== hold_word) begin
                    errors++;
                    $display("FAIL hold got=%h want=%h", {out_last, out_data}, hold_word);
                end
            end
            if (out_valid && out_ready) cap_q.push_back({out_last, out_data});
            lat_pend  <= r_en && !rempty;
            lat_word  <= rdata;
            hold_pend <= out_valid && !out_ready;
            hold_word <= {out_last, out_data};
        end else begin
            lat_pend  <= 1'b0;
            hold_pend <= 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        cap_q.delete();
        m_seq    = 8'd0;
        m_sum    = '0;
        m_pos    = 0;
        m_frames = 0;
    endtask

    // Each word lands in the FIFO and extends the expected framed stream.
    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr[10:0]] = w;
        wr_ptr++;
        if (m_pos == 0) exp_q.push_back({1'b0, 8'hA5, m_seq});
        exp_q.push_back({1'b0, w});
        m_sum = m_sum + w;
        m_pos++;
        if (m_pos == FL) begin
            exp_q.push_back({1'b1, m_sum});
            m_seq++;
            m_sum = '0;
            m_pos = 0;
            m_frames++;
        end
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        wr_ptr = 0;
        model_clear();
        tick(2);
        rrst_n = 1'b1;
        tick(2);
    endtask

    task automatic drain(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (cap_q.size() >= exp_q.size() && rd_ptr == wr_ptr) begin
                to = 1'b0;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        bit to;
        rrst_n = 1'b0;
        out_ready = 1'b1;
        model_clear();
        tick(2);
        checks++;
        if ({out_valid, out_last, r_en} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags v/l/ren=%b want 000", {out_valid, out_last, r_en});
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("FAIL rst_data got=%h want 0000", out_data);
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_fcnt got=%0d want 0", frame_cnt);
        end
        push(16'h1234);
        tick(1);
        checks++;
        if (r_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_ren got=%b want 0", r_en);
        end
        rrst_n = 1'b1;
        tick(2);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rel_early out_valid=%b want 0", out_valid);
        end
        tick(1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA500) begin
            errors++;
            $display("FAIL rel_hdr v=%b data=%h want 1 A500", out_valid, out_data);
        end
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        drain(200, to);
        checks++;
        if (to || cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_len got=%0d want=%0d", cap_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_word[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_basic();
        bit to;
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) push(16'(k));
        drain(200, to);
        checks++;
        if (to || cap_q.size() != 6 || cap_q[0] !== {1'b0, 16'hA500} ||
            cap_q[5] !== {1'b1, 16'h000A}) begin
            errors++;
            $display("FAIL basic_frame len=%0d want 6 with A500..last 000A", cap_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_word[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL basic_fcnt got=%0d want 1", frame_cnt);
        end
    endtask

    task automatic test_sum_wrap();
        bit to;
        do_reset();
        out_ready = 1'b1;
        push(16'hFFFF);
        push(16'hFFFF);
        push(16'h0002);
        push(16'h0001);
        drain(200, to);
        checks++;
        if (to || cap_q.size() != 6 || cap_q[5] !== {1'b1, 16'h0001}) begin
            errors++;
            $display("FAIL wrap_csum len=%0d last=%h want 6 10001", cap_q.size(),
                     (cap_q.size() > 5) ? cap_q[5] : 17'h0);
        end
    endtask

    task automatic test_underflow();
        bit to;
        do_reset();
        out_ready = 1'b1;
        push(16'($urandom));
        push(16'($urandom));
        tick(20);
        checks++;
        if (out_valid !== 1'b0 || r_en !== 1'b0 || cap_q.size() != 3) begin
            errors++;
            $display("FAIL under_stall v=%b ren=%b cap=%0d want 0 0 3", out_valid, r_en, cap_q.size());
        end
        push(16'($urandom));
        push(16'($urandom));
        drain(200, to);
        checks++;
        if (to || cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL under_len got=%0d want=%0d", cap_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL under_word[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [DW-1:0] held;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) push(16'($urandom));
        tick(5);
        held = out_data;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA500) begin
            errors++;
            $display("FAIL bp_hdr v=%b data=%h want 1 A500", out_valid, out_data);
        end
        for (int k = 0; k < 10; k++) begin
            tick(1);
            checks++;
            if (out_data !== held || r_en !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall data=%h ren=%b want %h 0", out_data, r_en, held);
            end
        end
        out_ready = 1'b1;
        drain(300, to);
        checks++;
        if (to || cap_q.size() != 12 || cap_q[6] !== {1'b0, 16'hA501}) begin
            errors++;
            $display("FAIL bp_frames len=%0d want 12 second header A501", cap_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_word[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int pushed = 0;
        do_reset();
        for (int c = 0; c < 3000 && pushed < 12 * FL; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                push(16'($urandom));
                pushed++;
            end
            tick(1);
        end
        out_ready = 1'b1;
        drain(500, to);
        checks++;
        if (to || cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_len got=%0d want=%0d", cap_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_word[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frame_cnt !== 8'(m_frames)) begin
            errors++;
            $display("FAIL rand_fcnt got=%0d want=%0d", frame_cnt, m_frames);
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) push(16'($urandom));
        for (int c = 0; c < 50 && rd_ptr < 2; c++) tick(1);
        rrst_n = 1'b0;
        #1;
        checks++;
        if (rd_ptr != 0 || {out_valid, out_last, r_en} !== 3'b000 ||
            out_data !== 16'h0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_rst v/l/ren=%b data=%h fcnt=%0d want 000 0000 0",
                     {out_valid, out_last, r_en}, out_data, frame_cnt);
        end
        wr_ptr = 0;
        model_clear();
        tick(2);
        rrst_n = 1'b1;
        tick(2);
        for (int k = 0; k < 4; k++) push(16'($urandom));
        drain(200, to);
        checks++;
        if (to || cap_q.size() != 6 || cap_q[0] !== {1'b0, 16'hA500}) begin
            errors++;
            $display("FAIL mid_hdr len=%0d want 6 header A500", cap_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_word[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_fcnt got=%0d want 1", frame_cnt);
        end
    endtask

    task automatic test_frame_wrap();
        bit to;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 256 * FL; k++) push(16'($urandom));
        drain(4000, to);
        checks++;
        if (to || frame_cnt !== 8'd0 || cap_q.size() != 256 * 6 ||
            cap_q[255 * 6] !== {1'b0, 16'hA5FF}) begin
            errors++;
            $display("FAIL fwrap_256 fcnt=%0d len=%0d want 0 %0d, header A5FF",
                     frame_cnt, cap_q.size(), 256 * 6);
        end
        for (int k = 0; k < FL; k++) push(16'($urandom));
        drain(200, to);
        checks++;
        if (to || cap_q.size() != exp_q.size() || frame_cnt !== 8'd1 ||
            cap_q[256 * 6] !== {1'b0, 16'hA500}) begin
            errors++;
            $display("FAIL fwrap_next fcnt=%0d len=%0d want 1 %0d, header A500",
                     frame_cnt, cap_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fwrap_word[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sum_wrap();
        test_underflow();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_frame_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
